fir_filter_stage: RTL
=====================

# fir_filter_stage

Sequential N-tap signed FIR stage that sits directly downstream of a sample FIFO and upstream of a result FIFO. It pops one sample when the input FIFO is non-empty and shifts it into a delay line. It then runs one multiply-accumulate per tap, scales and saturates the result, and pushes it into the output FIFO, stalling on full. Coefficients are run-time loadable between samples.

## Interface
- `B`, 8, sample and result width (signed two's complement)
- `C`, 8, coefficient width (signed)
- `N`, 4, number of taps (power of two, ≥2)
- `SHIFT`, 6, arithmetic right shift applied to the accumulator before saturation (`SHIFT ≤ C-2`)
- Derived: `NW = clog2(N)`, `A = B+C+NW` (accumulator width)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `in_empty`  in  1  input FIFO empty flag
- `in_data`  in  B  input FIFO read data (head word, valid while `in_empty`=0)
- `in_rd`  out  1  pop strobe to the input FIFO
- `out_full`  in  1  output FIFO full flag
- `out_wr`  out  1  push strobe to the output FIFO
- `out_data`  out  B  result word
- `coef_wr`  in  1  coefficient write strobe
- `coef_addr`  in  NW  tap index
- `coef_data`  in  C  coefficient value
- `busy`  out  1  high whenever state ≠ IDLE
- `sat`  out  1  high with `out_wr` when the pushed result was clipped

## Operation
- Delay line `x[0..N-1]` (`x[0]` newest), coefficients `c[0..N-1]`, accumulator `acc` (A bits), tap counter `k` (NW bits).
- IDLE:
  - If `coef_wr`=1: `c[coef_addr] <= coef_data`. This write has priority; `in_rd`=0 that cycle.
  - Else, if `in_empty`=0: `in_rd`=1 (combinational), `x[0] <= in_data`, `x[i] <= x[i-1]`, `acc <= 0`, `k <= 0`, go to MAC.
- MAC:
  - Each cycle: `acc <= acc + x[k]*c[k]` (full-precision signed product, sign-extended to A), `k <= k+1`.
  - After the cycle with `k==N-1`, go to PUSH.
  - `coef_wr` is ignored in MAC and PUSH.
- PUSH:
  - `r = acc >>> SHIFT`, saturated to B bits: above 2^(B-1)-1 clips to max, below -2^(B-1) clips to min.
  - `out_data` is driven from `r` combinationally in PUSH and from a holding register otherwise.
  - `out_wr = ~out_full`. On a write, go to IDLE.
  - While `out_full`=1, hold state; `acc` and `out_data` stay stable.
- `sat` = (PUSH & ~`out_full` & clipped).
- The accumulator cannot overflow: A bits covers N worst-case products.

## Timing
- Reset values:
  - state=IDLE, `x[*]`=0, `acc`=0, `k`=0, `out_data`=0
  - `c[0]`=2^SHIFT, `c[1..N-1]`=0 (identity passthrough)
  - `in_rd`=`out_wr`=`busy`=`sat`=0
- Pop at edge T0. MAC at T1..TN. PUSH asserts `out_wr` in cycle TN+1 if not full.
- Throughput: one sample per N+2 cycles when neither FIFO stalls.
- `in_rd` is asserted only when `in_empty`=0, so the block never pops an empty FIFO. `out_wr` is asserted only when `out_full`=0.
- `in_rd` and `out_wr` are never high in the same cycle.
- `reset` mid-operation takes effect at the next edge: any partial result is discarded with no `out_wr`, and the coefficients return to identity.

## Structure
- Shared package `fir_pkg`:
  - state encodings `S_IDLE`, `S_MAC`, `S_PUSH`
  - `clog2` function
  - saturate function (width-parameterised shift plus clip)
- One sub-module: `fir_mac`, a signed B×C multiply with A-bit accumulate and a clear input. The top level holds the FSM, delay line, coefficient file and FIFO handshakes.

## Test plan
1. Identity after reset (defaults): input FIFO gets 10, −5, 127. Required: `out_data` 10, −5, 127 in order, `out_wr` pulses 6 cycles apart, `sat`=0.
2. Moving average: write `c`={16,16,16,16}, then feed 40, 40, 40, 40. Required: outputs 10, 20, 30, 40.
3. Saturation: `c`={127,127,0,0}, feed 127, then −128. Required:
   - first output 127 with `sat`=1 (252 clipped)
   - second output: `acc` = −128·127 + 127·127 = −127, shifted = −2; `out_data`=−2 with `sat`=0
   - then feed −128 and −128: output −128 with `sat`=1.
4. Back-pressure: hold `out_full`=1 for 5 cycles while in PUSH. Required: `out_wr`=0, `out_data` stable, `in_rd`=0 throughout; one `out_wr` in the cycle after release, then normal pops resume.
5. Coefficient priority:
   - `coef_wr` during MAC: ignored; the result uses the old `c`.
   - `coef_wr` in IDLE with `in_empty`=0: `c` updated, `in_rd` deferred exactly one cycle.
6. Reset on the second MAC cycle: next cycle `busy`=0, `out_data`=0, `x[*]`=0, identity coefficients restored, no `out_wr` ever issued for the aborted sample.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state encoding, clog2 and shift/saturate helpers for the FIR stage
// Purpose: types and helpers imported by fir_mac and fir_filter_stage.
// Contents:
//   state_t   - FSM encoding (S_IDLE, S_MAC, S_PUSH)
//   sat_t     - shifted/clipped value plus clip flag
//   clog2     - ceiling log2 for parameter derivation
//   sat_shift - arithmetic right shift followed by clip to a signed width
package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [63:0] value;
    logic               clipped;
  } sat_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // The accumulator is passed sign-extended to 64 bits so one helper serves any width.
  function automatic sat_t sat_shift(input logic signed [63:0] acc,
                                     input int shift,
                                     input int width);
    sat_t               r;
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    shifted = acc >>> shift;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (width - 1));
    if (shifted > max_v) begin
      r.value   = max_v;
      r.clipped = 1'b1;
    end else if (shifted < min_v) begin
      r.value   = min_v;
      r.clipped = 1'b1;
    end else begin
      r.value   = shifted;
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - signed BxC multiply with A-bit accumulate
// Purpose: one multiply-accumulate per enabled cycle; clear zeroes the sum.
// Ports:
//   i_clk, i_reset - clock, synchronous active-high reset
//   i_clear        - zero the accumulator (takes priority over i_en)
//   i_en           - add i_x*i_c this cycle
//   i_x, i_c       - signed sample and coefficient
//   o_acc          - running signed sum
module fir_mac
  import fir_pkg::*;
#(
  parameter int B = 8,
  parameter int C = 8,
  parameter int A = 18
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_en,
  input  logic signed [B-1:0] i_x,
  input  logic signed [C-1:0] i_c,
  output logic signed [A-1:0] o_acc
);

  logic signed [B+C-1:0] w_prod;
  logic signed [A-1:0]   r_acc;

  assign w_prod = i_x * i_c;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + A'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fir_filter_stage.sv
// rtl/fir_filter_stage.sv - sequential N-tap signed FIR between an input and an output FIFO
// Purpose: pops one sample, runs N MAC cycles, scales/saturates and pushes the result.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   in_empty, in_data, in_rd      - input FIFO head, pop strobe
//   out_full, out_wr, out_data    - output FIFO push interface
//   coef_wr, coef_addr, coef_data - coefficient load (accepted in IDLE only)
//   busy                          - high whenever not IDLE
//   sat                           - result being pushed was clipped
module fir_filter_stage
  import fir_pkg::*;
#(
  parameter  int B     = 8,
  parameter  int C     = 8,
  parameter  int N     = 4,
  parameter  int SHIFT = 6,
  localparam int NW    = clog2(N),
  localparam int A     = B + C + NW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_empty,
  input  logic [B-1:0]  in_data,
  output logic          in_rd,
  input  logic          out_full,
  output logic          out_wr,
  output logic [B-1:0]  out_data,
  input  logic          coef_wr,
  input  logic [NW-1:0] coef_addr,
  input  logic [C-1:0]  coef_data,
  output logic          busy,
  output logic          sat
);

  // c[0] = 2^SHIFT with the rest zero makes the stage a passthrough.
  localparam logic signed [C-1:0] COEF_UNITY = C'(1 << SHIFT);

  state_t                r_state;
  logic [NW-1:0]         r_k;
  logic signed [B-1:0]   r_x [N];
  logic signed [C-1:0]   r_c [N];
  logic [B-1:0]          r_out_data;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_clear;
  logic signed [A-1:0]   w_acc;
  sat_t                  w_sat;
  logic [B-1:0]          w_result;
  logic                  w_unused_hi;

  // Strobes are gated by reset so an aborted sample never touches either FIFO.
  assign w_pop   = (r_state == S_IDLE) && !coef_wr && !in_empty && !reset;
  assign w_push  = (r_state == S_PUSH) && !out_full && !reset;
  assign w_clear = w_pop;

  fir_mac #(
    .B (B),
    .C (C),
    .A (A)
  ) u_mac (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (w_clear),
    .i_en    (r_state == S_MAC),
    .i_x     (r_x[r_k]),
    .i_c     (r_c[r_k]),
    .o_acc   (w_acc)
  );

  assign w_sat       = sat_shift({{(64-A){w_acc[A-1]}}, w_acc}, SHIFT, B);
  assign w_result    = w_sat.value[B-1:0];
  assign w_unused_hi = ^w_sat.value[63:B];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_out_data <= '0;
      for (int i = 0; i < N; i++) begin
        r_x[i] <= '0;
        r_c[i] <= (i == 0) ? COEF_UNITY : '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (coef_wr) begin
            r_c[coef_addr] <= coef_data;
          end else if (!in_empty) begin
            r_x[0] <= in_data;
            for (int i = 1; i < N; i++) begin
              r_x[i] <= r_x[i-1];
            end
            r_k     <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_k <= r_k + 1'b1;
          if (r_k == NW'(N - 1)) begin
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (!out_full) begin
            r_out_data <= w_result;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_rd    = w_pop;
  assign out_wr   = w_push;
  assign out_data = (r_state == S_PUSH) ? w_result : r_out_data;
  assign busy     = (r_state != S_IDLE);
  assign sat      = w_push && w_sat.clipped;

endmodule
